// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared 1-bit add cell (two half adds + carry register) stepped LSB-first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] opa_r, opa_s;
  logic [WIDTH-1:0] opb_r, opb_s;
  logic [WIDTH-1:0] sum_r, sum_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             carry_r, carry_s;
  logic             cout_r, cout_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [1:0]       ha0_s, ha1_s;
  logic             bit_s, cnext_s, sub_s;

  // Returns {carry, sum} of a single half-adder cell.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

`ifdef SERIAL_ADD_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  // Full add built as two cascaded half adds; their carries never both set, so OR suffices.
  assign ha0_s   = half_add(opa_r[0], opb_r[0]);
  assign ha1_s   = half_add(ha0_s[0], carry_r);
  assign bit_s   = ha1_s[0];
  assign cnext_s = ha0_s[1] | ha1_s[1];

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_s = state_r;
    opa_s   = opa_r;
    opb_s   = opb_r;
    sum_s   = sum_r;
    cnt_s   = cnt_r;
    carry_s = carry_r;
    cout_s  = cout_r;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          opa_s   = a;
          opb_s   = sub_s ? ~b : b;
          carry_s = sub_s;
          cnt_s   = '0;
          sum_s   = '0;
          busy_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        sum_s   = {bit_s, sum_r[WIDTH-1:1]};
        opa_s   = {1'b0, opa_r[WIDTH-1:1]};
        opb_s   = {1'b0, opb_r[WIDTH-1:1]};
        carry_s = cnext_s;
        cnt_s   = cnt_r + CW'(1'b1);
        if (cnt_r == CW'(WIDTH - 1)) begin
          cout_s  = cnext_s;
          done_s  = 1'b1;
          state_s = DONE;
        end else begin
          busy_s  = 1'b1;
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; busy/done are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      opa_r   <= '0;
      opb_r   <= '0;
      sum_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      opa_r   <= opa_s;
      opb_r   <= opb_s;
      sum_r   <= sum_s;
      cnt_r   <= cnt_s;
      carry_r <= carry_s;
      cout_r  <= cout_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=2 instances).
// Subtract vectors are exercised when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start8, start2;
  logic [7:0] a8, b8, sum8;
  logic [1:0] a2, b2, sum2;
  logic       busy8, done8, cout8;
  logic       busy2, done2, cout2;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub8, sub2;
`endif
  int         nchecks;
  int         nerrors;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub2),
`endif
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation with full timing checks; operands are scrambled after accept.
  task automatic do_op8(input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] es, input logic ec);
    @(negedge clk);
    a8 = x; b8 = y; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = ~x; b8 = 8'h5A;
    chk("load_clr_sum", 32'(sum8), 32'd0);
    chk("busy_t0", 32'(busy8), 32'd1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("busy_run", 32'(busy8), 32'd1);
      chk("done_run", 32'(done8), 32'd0);
    end
    @(negedge clk);
    chk("done_pulse", 32'(done8), 32'd1);
    chk("busy_done", 32'(busy8), 32'd0);
    chk("sum8", 32'(sum8), 32'(es));
    chk("cout8", 32'(cout8), 32'(ec));
    @(negedge clk);
    chk("done_fall", 32'(done8), 32'd0);
    chk("sum8_hold", 32'(sum8), 32'(es));
    chk("cout8_hold", 32'(cout8), 32'(ec));
  endtask

  initial begin
    nchecks = 0;
    nerrors = 0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start2 = 1'b0; a2 = 2'b00; b2 = 2'b00;
`ifdef SERIAL_ADD_SUB_EN
    sub8 = 1'b0; sub2 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    chk("rst_sum2", 32'(sum2), 32'd0);
    rst_n = 1'b1;

    do_op8(8'h3C, 8'h05, 8'h41, 1'b0);
    do_op8(8'hFF, 8'h01, 8'h00, 1'b1);
    do_op8(8'hA5, 8'h5A, 8'hFF, 1'b0);
    // Idle cycles with moving operands: result must hold until the next accept.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a8 = 8'(i * 7); b8 = 8'(i * 13);
      chk("idle_hold_sum", 32'(sum8), 32'hFF);
      chk("idle_hold_cout", 32'(cout8), 32'd0);
      chk("idle_busy", 32'(busy8), 32'd0);
    end
    do_op8(8'h80, 8'h80, 8'h00, 1'b1);

    // start held high with operands changing every cycle.
    @(negedge clk);
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        chk("hold_done", 32'(done8), 32'((k == 9) || (k == 19)));
        chk("hold_busy", 32'(busy8), 32'(((k >= 1) && (k <= 8)) || ((k >= 11) && (k <= 18))));
        if (k == 9) chk("hold_sum_a", 32'(sum8), 32'h50);
        else if (k == 19) chk("hold_sum_b", 32'(sum8), 32'hA0);
      end
      a8 = 8'(8'h10 + k * 3);
      b8 = 8'(8'h40 + k * 5);
      start8 = (k < 20);
      @(negedge clk);
    end
    chk("hold_idle_busy", 32'(busy8), 32'd0);

    // Asynchronous reset four cycles into RUN.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy8), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_sum", 32'(sum8), 32'd0);
    chk("abort_cout", 32'(cout8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done8), 32'd0);
      chk("abort_no_busy", 32'(busy8), 32'd0);
    end
    do_op8(8'h12, 8'h34, 8'h46, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    sub8 = 1'b1;
    do_op8(8'h05, 8'h07, 8'hFE, 1'b0);
    do_op8(8'h07, 8'h05, 8'h02, 1'b1);
    sub8 = 1'b0;
    do_op8(8'h07, 8'h05, 8'h0C, 1'b0);
`endif

    // WIDTH=2 instance.
    @(negedge clk);
    a2 = 2'b11; b2 = 2'b01; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; a2 = 2'b00; b2 = 2'b00;
    chk("w2_busy1", 32'(busy2), 32'd1);
    chk("w2_done1", 32'(done2), 32'd0);
    @(negedge clk);
    chk("w2_busy2", 32'(busy2), 32'd1);
    chk("w2_done2", 32'(done2), 32'd0);
    @(negedge clk);
    chk("w2_done", 32'(done2), 32'd1);
    chk("w2_busy", 32'(busy2), 32'd0);
    chk("w2_sum", 32'(sum2), 32'd0);
    chk("w2_cout", 32'(cout2), 32'd1);
    @(negedge clk);
    chk("w2_done_fall", 32'(done2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
